// File: rtl/memory_addr_sequencer.sv
// Address sequencer for the image-scaling frame memory: turns one request into
// a single beat or a SCALE x SCALE row-major block of addresses, with stall and range check.
module memory_addr_sequencer #(
  parameter int ADDR_WIDTH = 17,
  parameter int IMG_WIDTH  = 160,
  parameter int SCALE      = 2,
  parameter int MEM_DEPTH  = 76800
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [2:0]            operation,
  input  logic [ADDR_WIDTH-1:0] addr_base,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  addr_valid,
  output logic                  wr_en,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int EW = ADDR_WIDTH + 2;
  localparam logic [CW-1:0]         LAST_IDX = CW'(SCALE - 1);
  localparam logic [EW-1:0]         SPAN     = EW'((SCALE - 1) * IMG_WIDTH + SCALE - 1);
  localparam logic [EW-1:0]         LIMIT    = EW'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(IMG_WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]            state;
  logic [CW-1:0]         col;
  logic [CW-1:0]         row;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] row_start;
  logic                  block_q;
  logic                  wr_q;

  logic          is_block;
  logic [EW-1:0] last_ext;
  logic          in_range;
  logic          last_beat;
  logic          accept_start;

  // Range check uses two spare bits so an out-of-range block can never wrap into range.
  assign is_block     = operation[0] ^ operation[1];
  assign last_ext     = {2'b00, addr_base} + (is_block ? SPAN : {EW{1'b0}});
  assign in_range     = (last_ext <= LIMIT);
  assign accept_start = (state == S_IDLE) && start && in_range;
  assign last_beat    = !block_q || ((row == LAST_IDX) && (col == LAST_IDX));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      col   <= '0;
      row   <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (in_range) begin
              col   <= '0;
              row   <= '0;
              state <= S_ISSUE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (mem_ready) begin
            if (last_beat) begin
              state <= S_DONE;
            end else if (col == LAST_IDX) begin
              col <= '0;
              row <= row + CW'(1);
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Address path: row_start accumulates the row stride, addr_q walks the columns.
  always_ff @(posedge clock) begin
    if (accept_start) begin
      addr_q    <= addr_base;
      row_start <= addr_base;
      block_q   <= is_block;
      wr_q      <= operation[2];
    end else if ((state == S_ISSUE) && mem_ready && !last_beat) begin
      if (col == LAST_IDX) begin
        row_start <= row_start + STRIDE;
        addr_q    <= row_start + STRIDE;
      end else begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
      end
    end
  end

  assign addr_valid = (state == S_ISSUE);
  assign addr_out   = addr_valid ? addr_q : '0;
  assign wr_en      = addr_valid & wr_q;
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign err        = err_q;

endmodule
